inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Instruction fetch front end. Drives the instruction-memory request/response port and supplies (address, instruction) pairs to the IF/ID pipeline register.
- Owns the PC. Uses a small in-order prefetch FIFO to decouple memory latency from decode.
- Obeys hold and jump/flush from the pipeline controller. Invalid slots are filled with NOPs so IF/ID always sees a legal instruction.

Parameters:
- ADDR_WIDTH, 32, PC / instruction address width.
- INST_WIDTH, 32, instruction width.
- PC_INIT, 32'h8000_0000, PC after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).
- FIFO_DEPTH, 2, prefetch entries; also the maximum outstanding requests (power of 2, ≥2).

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- MemReqValid  out  1  fetch request valid.
- MemReqReady  in  1  memory accepts request.
- MemReqAddr  out  ADDR_WIDTH  fetch address (word aligned).
- MemRespValid  in  1  response data valid; in order, ≥1 cycle after acceptance.
- MemRespData  in  INST_WIDTH  fetched instruction.
- HoldIn  in  1  controller hold: do not advance the output.
- JumpFlag  in  1  redirect/flush request.
- JumpAddr  in  ADDR_WIDTH  redirect target.
- InstAddrOut  out  ADDR_WIDTH  address of the presented instruction (to IF/ID).
- InstOut  out  INST_WIDTH  presented instruction (to IF/ID).
- InstValidOut  out  1  presented instruction is real, not a bubble.

Behaviour:
- Reset (async, immediate):
  - PC=PC_INIT; FIFO empty; outstanding=0; discard=0.
  - MemReqValid=0; InstValidOut=0; InstOut=NOP_INST; InstAddrOut=PC_INIT.
- Credit:
  - MemReqValid = !Rst && !JumpFlag && (outstanding + fifo_count < FIFO_DEPTH).
  - MemReqAddr = PC.
  - Request accepted when MemReqValid && MemReqReady: PC += 4 (modulo 2^ADDR_WIDTH, wraps silently); outstanding += 1.
- Response (MemRespValid):
  - discard>0: discard -= 1, data dropped.
  - Otherwise: push {addr, data} into FIFO. Addresses are tracked in a parallel in-order queue of issued PCs.
  - Outstanding -= 1 in either case.
  - Credit guarantees the FIFO never overflows. A response with outstanding==0 is a protocol error: ignore it.
- Output:
  - FIFO non-empty: InstValidOut=1, InstOut/InstAddrOut = FIFO head (combinational from registered storage).
  - FIFO empty: InstValidOut=0, InstOut=NOP_INST, InstAddrOut=last presented address.
  - Pop when InstValidOut && !HoldIn. While HoldIn=1, outputs are stable cycle to cycle.
  - Bypass: a response arriving into an empty FIFO is presented the next cycle (1-cycle minimum latency resp→out).
- Jump (JumpFlag=1 at an edge):
  - PC←JumpAddr; FIFO cleared; no new request that cycle.
  - discard ← outstanding_after_this_cycle, i.e. outstanding minus 1 if a response also arrives that cycle, since that response is itself dropped.
  - Next cycle: InstValidOut=0 and InstOut=NOP_INST.
  - Jump wins over simultaneous pop, push and hold.
  - A new jump while discard>0 overwrites PC and recomputes discard from the current outstanding count.
- JumpAddr low 2 bits are forced to 0.
- HoldIn and JumpFlag together: jump applies (flush); the output becomes a bubble.
- MemReqReady=0 stalls issue only; responses and output continue.

Test Plan:
1. Reset released, MemReqReady=1, 1-cycle responses 0xA0..: requests at 0x80000000, 0x80000004…; outputs (0x80000000,0xA0), (0x80000004,0xA1) consecutively with InstValidOut=1.
2. HoldIn=1 for 5 cycles with FIFO full: MemReqValid=0 after 2 outstanding/filled; InstOut/InstAddrOut unchanged; release → next entry presented the following cycle, no loss or duplication.
3. JumpFlag with JumpAddr=0x80000100 and 2 requests outstanding: both later responses dropped; next presented pair is (0x80000100, resp); a bubble (NOP 0x13, valid=0) appears in between.
4. Jump in the same cycle as MemRespValid and HoldIn: that response is dropped, hold ignored, discard=outstanding-1; the first valid output is the target instruction.
5. PC=0xFFFFFFFC fetch: next MemReqAddr=0x00000000.
6. Rst asserted mid-stream with 2 outstanding: outputs reset immediately (async); after release fetch restarts at PC_INIT. The bench holds memory reset too, so no stale responses arrive.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch front end with PC, credit-limited issue and prefetch FIFO
module inst_fetch #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    INST_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] PC_INIT    = ADDR_WIDTH'(32'h8000_0000),
   parameter logic [INST_WIDTH-1:0] NOP_INST   = INST_WIDTH'(32'h0000_0013),
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  Clk,
   input  logic                  Rst,
   output logic                  MemReqValid,
   input  logic                  MemReqReady,
   output logic [ADDR_WIDTH-1:0] MemReqAddr,
   input  logic                  MemRespValid,
   input  logic [INST_WIDTH-1:0] MemRespData,
   input  logic                  HoldIn,
   input  logic                  JumpFlag,
   input  logic [ADDR_WIDTH-1:0] JumpAddr,
   output logic [ADDR_WIDTH-1:0] InstAddrOut,
   output logic [INST_WIDTH-1:0] InstOut,
   output logic                  InstValidOut
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] pc;
   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      discard;

   // Addresses of issued requests whose responses will be kept, oldest first
   logic [ADDR_WIDTH-1:0] iss_addr [FIFO_DEPTH];
   logic [PTR_W-1:0]      iss_wr;
   logic [PTR_W-1:0]      iss_rd;

   // Prefetch FIFO of (address, instruction) pairs
   logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
   logic [INST_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]      fifo_wr;
   logic [PTR_W-1:0]      fifo_rd;
   logic [CNT_W-1:0]      fifo_count;
   logic [ADDR_WIDTH-1:0] last_addr;

   logic                  fifo_empty;
   logic [CNT_W:0]        credit_used;
   logic                  req_fire;
   logic                  resp_ok;
   logic                  resp_drop;
   logic                  push;
   logic                  pop;
   logic [ADDR_WIDTH-1:0] jump_target;

   assign fifo_empty  = (fifo_count == '0);
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign jump_target = JumpAddr & ~ADDR_WIDTH'(3);

   // Every in-flight request holds a FIFO slot, so the FIFO can never overflow
   assign MemReqValid = !Rst && !JumpFlag && (credit_used < DEPTH_C);
   assign MemReqAddr  = pc;
   assign req_fire    = MemReqValid && MemReqReady;

   // A response with nothing outstanding is a protocol error and is ignored
   assign resp_ok   = MemRespValid && (outstanding != '0);
   assign resp_drop = resp_ok && (discard != '0);
   assign push      = resp_ok && (discard == '0) && !JumpFlag;
   assign pop       = !fifo_empty && !HoldIn && !JumpFlag;

   assign InstValidOut = !fifo_empty;
   assign InstOut      = fifo_empty ? NOP_INST  : fifo_data[fifo_rd];
   assign InstAddrOut  = fifo_empty ? last_addr : fifo_addr[fifo_rd];

   // PC, in-flight request count and count of responses still to be dropped
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         pc          <= PC_INIT;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         if (JumpFlag)
            pc <= jump_target;
         else if (req_fire)
            pc <= pc + ADDR_WIDTH'(4);

         if (req_fire && !resp_ok)
            outstanding <= outstanding + CNT_W'(1);
         else if (!req_fire && resp_ok)
            outstanding <= outstanding - CNT_W'(1);

         // A response landing on the jump edge is itself dropped, so it is not counted
         if (JumpFlag)
            discard <= outstanding - CNT_W'(resp_ok);
         else if (resp_drop)
            discard <= discard - CNT_W'(1);
      end
   end

   // Issue-address queue pointers; a jump turns every in-flight request into a discard
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         iss_wr <= '0;
         iss_rd <= '0;
      end else if (JumpFlag) begin
         iss_wr <= '0;
         iss_rd <= '0;
      end else begin
         if (req_fire)
            iss_wr <= iss_wr + PTR_W'(1);
         if (push)
            iss_rd <= iss_rd + PTR_W'(1);
      end
   end

   // Prefetch FIFO pointers and occupancy; jump flush wins over push and pop
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         fifo_count <= '0;
      end else if (JumpFlag) begin
         fifo_wr    <= '0;
         fifo_rd    <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            fifo_wr <= fifo_wr + PTR_W'(1);
         if (pop)
            fifo_rd <= fifo_rd + PTR_W'(1);
         if (push && !pop)
            fifo_count <= fifo_count + CNT_W'(1);
         else if (!push && pop)
            fifo_count <= fifo_count - CNT_W'(1);
      end
   end

   // Remember the address on display so a bubble keeps showing it
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         last_addr <= PC_INIT;
      else if (!fifo_empty)
         last_addr <= fifo_addr[fifo_rd];
   end

   // Queue storage needs no reset; pointers define which entries are live
   always_ff @(posedge Clk) begin
      if (req_fire)
         iss_addr[iss_wr] <= pc;
      if (push) begin
         fifo_addr[fifo_wr] <= iss_addr[iss_rd];
         fifo_data[fifo_wr] <= MemRespData;
      end
   end

endmodule
